// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: one SW-bit slice per stage, carry registered between stages.
// Optional subtract mode is compiled in with `define ADDER_SUB_EN.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int SW = WIDTH / STAGES;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Per-stage token: operands (skew), partial sum (deskew), carry, valid
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ov_q;

    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic             src_v [STAGES];

    logic [WIDTH-1:0] n_s [STAGES];
    logic             n_c [STAGES];
    logic             ov_n;
    logic             advance;

    assign advance  = !(v_q[STAGES-1] && !out_ready);
    assign in_ready = !rst && advance;

    always_comb begin
        src_a[0] = a;
        src_b[0] = b_eff;
        src_s[0] = '0;
        src_c[0] = cin_eff;
        src_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
            src_v[k] = v_q[k-1];
        end
    end

    always_comb begin
        logic [SW:0] part;
        part = '0;
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, src_a[k][k*SW +: SW]}
                 + {1'b0, src_b[k][k*SW +: SW]}
                 + {{SW{1'b0}}, src_c[k]};
            n_s[k] = src_s[k];
            n_s[k][k*SW +: SW] = part[SW-1:0];
            n_c[k] = part[SW];
        end
        ov_n = (src_a[STAGES-1][WIDTH-1] == src_b[STAGES-1][WIDTH-1])
            && (n_s[STAGES-1][WIDTH-1] != src_a[STAGES-1][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ov_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= src_a[k];
                b_q[k] <= src_b[k];
                s_q[k] <= n_s[k];
                c_q[k] <= n_c[k];
                v_q[k] <= src_v[k];
            end
            ov_q <= ov_n;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign overflow  = ov_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, STAGES=4): queue model plus directed vectors.
module tb_pipelined_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int total = 0;
    int bad   = 0;
    int got   = 0;

    logic [W+1:0] q[$];

    pipelined_adder #(.WIDTH(W), .STAGES(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
`ifdef ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns {overflow, cout, sum} from plain wide arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic s);
        logic [W-1:0] ye;
        logic         ce;
        logic [W:0]   r;
        ye = y;
        ce = ci;
`ifdef ADDER_SUB_EN
        if (s) begin
            ye = ~y;
            ce = 1'b1;
        end
`else
        if (s) ce = ci;
`endif
        r = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, ce};
        return {(x[W-1] == ye[W-1]) && (r[W-1] != x[W-1]), r};
    endfunction

    // Compare process: pops the model on every out-transfer, checks stall stability
    logic         prev_stall = 1'b0;
    logic [W+1:0] prev_out = '0;
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_out", {out_valid, overflow, cout, sum}, {1'b1, prev_out});
            end
            if (out_valid && out_ready) begin
                got++;
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("model_result", {overflow, cout, sum}, q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
            prev_stall = out_valid && !out_ready;
            prev_out = {overflow, cout, sum};
        end
    end

    task automatic send_check(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic ci, input logic s, input logic [W-1:0] es,
                              input logic ec, input logic eo);
        int lat;
        @(posedge clk); #1;
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (out_valid || lat >= 12) break;
            @(posedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, 4);
        chk({name, "_sum"}, sum, es);
        chk({name, "_cout"}, cout, ec);
        chk({name, "_ovf"}, overflow, eo);
        @(negedge clk);
        chk({name, "_one_cycle"}, out_valid, 0);
    endtask

    logic [W-1:0] va [16];
    logic [W-1:0] vb [16];
    logic         vc [16];

    initial begin
        int idx;
        int cyc;
        int g0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        send_check("add_1_2", 32'h1, 32'h2, 1'b0, 1'b0, 32'h3, 1'b0, 1'b0);
        send_check("carry_chain", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        send_check("pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send_check("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        send_check("slice_carry", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                   32'h0100_0000, 1'b0, 1'b0);

        // Streaming with a 4-cycle downstream stall
        for (int i = 0; i < 16; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
            vc[i] = 1'($urandom_range(0, 1));
        end
        va[3] = 32'hFFFF_FFFF;
        vb[3] = 32'h0000_0001;
        g0 = got;
        idx = 0;
        cyc = 0;
        while (idx < 16 && cyc < 80) begin
            @(posedge clk); #1;
            a = va[idx]; b = vb[idx]; cin = vc[idx]; sub = 1'b0;
            in_valid = 1'b1;
            out_ready = !(cyc >= 6 && cyc <= 9);
            @(negedge clk);
            if (cyc >= 6 && cyc <= 9) chk("stall_in_ready", in_ready, 0);
            if (in_ready) idx++;
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        chk("stream_count", got - g0, 16);
        chk("stream_drained", q.size(), 0);

        // Reset with three tokens in flight
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a = 32'h10 + i; b = 32'h20; cin = 1'b0; in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        g0 = got;
        repeat (6) @(negedge clk);
        chk("mid_rst_no_results", got - g0, 0);
        send_check("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
                   32'h2345_678A, 1'b0, 1'b0);

`ifdef ADDER_SUB_EN
        send_check("sub_5_7", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_check("sub_7_5", 32'h7, 32'h5, 1'b1, 1'b1, 32'h2, 1'b1, 1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry adder: the next generation of the team's 8-bit combinational adder. It splits a WIDTH-bit add into STAGES equal slices, computes one slice per pipeline stage, and carries the inter-slice carry through registers. It accepts one operand pair per cycle under a valid/ready handshake and reports carry-out and signed overflow. It is the datapath adder for wide accumulators and address generators where a single-cycle ripple chain misses timing.

## Interface
- WIDTH, 32: operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4: number of pipeline stages, 1..WIDTH. Slice width is SW = WIDTH/STAGES.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair present on a/b/cin.
- in_ready  out  1  block accepts an operand pair this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to bit 0.
- sub  in  1  present only with ADDER_SUB_EN: subtract request.
- out_valid  out  1  result present on sum/cout/overflow.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- overflow  out  1  signed overflow: a[MSB]==b_eff[MSB] and sum[MSB]!=a[MSB].

## Operation
- One clock, reset synchronous and active-high (fixed).
- Stage k (0..STAGES-1) adds slice k of a and b_eff plus the carry registered from stage k-1. Stage 0 uses cin_eff. Slice k covers bits [k*SW+SW-1 : k*SW].
- Upper operand slices not yet consumed travel with the token in skew registers. Completed lower sum slices travel in deskew registers, so all WIDTH sum bits leave stage STAGES-1 together.
- Each stage holds one valid bit. Bubbles are allowed: in_valid=0 inserts an empty slot.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Stall: the pipeline advances when !(out_valid && !out_ready). in_ready equals this advance condition and is 0 while rst=1.
- While stalled, every stage and every output (sum, cout, overflow, out_valid) holds stable.
- overflow is computed from the MSB of a, the MSB of b_eff and the MSB of sum, all carried with the token.
- No arithmetic saturation: sum wraps modulo 2^WIDTH, and cout reports the wrap.

## Timing
- Latency: a pair accepted in cycle N appears with out_valid=1 in cycle N+STAGES, provided there is no stall.
- Throughput: one result per cycle when out_ready is held at 1.
- Reset values: out_valid=0, sum=0, cout=0, overflow=0, all stage valid bits 0, all carry registers 0. in_ready=0 during reset and 1 in the first cycle after reset.
- Reset mid-operation: all in-flight tokens are discarded and no result is emitted for them.
- Simultaneous out-transfer and in-transfer in a full pipeline: both occur and occupancy stays constant.
- STAGES=1 degenerates to a registered adder with latency 1. STAGES=WIDTH gives one bit per stage.
- in_ready depends combinationally on out_ready. There is no other combinational input-to-output path.

## Configuration
- ADDER_SUB_EN defined:
  - The sub port exists.
  - With sub=1: b_eff = ~b, cin_eff = 1, and cin is ignored. This gives sum = a - b, and cout=1 means no borrow.
  - sub is sampled with the operands and travels with the token.
- ADDER_SUB_EN undefined:
  - The sub port is absent.
  - b_eff = b and cin_eff = cin.

## Test plan
- Reset, then a=0x0000_0001, b=0x0000_0002, cin=0 (WIDTH=32, STAGES=4) -> 4 cycles later sum=0x0000_0003, cout=0, overflow=0, out_valid for exactly 1 cycle.
- a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, overflow=0. Verifies the carry crosses all 4 slice boundaries.
- a=0x7FFF_FFFF, b=0x0000_0001 -> sum=0x8000_0000, overflow=1, cout=0. Then a=0x8000_0000, b=0x8000_0000 -> sum=0, cout=1, overflow=1.
- Back-to-back stream of 16 random pairs with out_ready held low for cycles 6-9 -> in_ready low during the stall, outputs frozen, all 16 results in order and matching the reference model, no drops or duplicates.
- Assert rst with 3 tokens in flight -> out_valid=0 next cycle, no results for those tokens, and a new pair after reset completes with 4-cycle latency.
- ADDER_SUB_EN: sub=1, a=5, b=7 -> sum=0xFFFF_FFFE, cout=0. Then sub=1, a=7, b=5 -> sum=2, cout=1.
